// File: rtl/spi_flash_slave.sv
// Minimal SPI mode-0 serial NOR flash responder backed by an internal byte array.
// SPI pins are oversampled on clk; supports WREN, WRDI, RDSR, JEDEC ID, READ, PAGE PROGRAM, CHIP ERASE.
module spi_flash_slave #(
    parameter int          P_MEM_DEPTH   = 256,
    parameter int          P_PROG_CYCLES = 64,
    parameter logic [23:0] P_JEDEC_ID    = 24'hEF4018
) (
    input  logic clk,
    input  logic rst,
    input  logic i_spi_cs,
    input  logic i_spi_clk,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
    output logic o_busy,
    output logic o_wel
);

    localparam int AW           = $clog2(P_MEM_DEPTH);
    localparam int ERASE_CYCLES = (P_PROG_CYCLES > P_MEM_DEPTH) ? P_PROG_CYCLES : P_MEM_DEPTH;
    localparam int CW           = $clog2(ERASE_CYCLES + 1);

    localparam logic [CW-1:0] BUSY_ONE   = CW'(1);
    localparam logic [CW-1:0] BUSY_PROG  = CW'(P_PROG_CYCLES);
    localparam logic [CW-1:0] BUSY_ERASE = CW'(ERASE_CYCLES);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(P_MEM_DEPTH - 1);

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_JEDEC = 8'h9F;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_CE    = 8'hC7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA_OUT,
        ST_DATA_IN,
        ST_WAIT_CS,
        ST_IGNORE
    } state_t;

    state_t state_r, next_state_s;

    logic [2:0]    cs_sync_r, sclk_sync_r;
    logic [1:0]    mosi_sync_r;
    logic [4:0]    bit_cnt_r;
    logic [7:0]    shift_r, opcode_r, tx_r;
    logic [2:0]    tx_cnt_r;
    logic [1:0]    id_idx_r;
    logic [23:0]   addr_r;
    logic          prog_any_r, miso_r, busy_r, wel_r, erase_active_r;
    logic [CW-1:0] busy_cnt_r;
    logic [AW-1:0] erase_addr_r;
    logic [7:0]    mem_r [P_MEM_DEPTH];

    logic          cs_s, cs_fall_s, sclk_rise_s, sclk_fall_s, mosi_s, prog_we_s;
    logic [7:0]    shift_full_s, status_s, out_src_s;
    logic [23:0]   addr_full_s;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = P_JEDEC_ID[23:16];
            2'd1:    b = P_JEDEC_ID[15:8];
            2'd2:    b = P_JEDEC_ID[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic state_t decode_op(input logic [7:0] op, input logic busy, input logic wel);
        state_t st;
        if (busy && (op != OP_RDSR)) begin
            st = ST_IGNORE;
        end else begin
            case (op)
                OP_WREN, OP_WRDI, OP_CE: st = ST_WAIT_CS;
                OP_RDSR, OP_JEDEC:       st = ST_DATA_OUT;
                OP_READ:                 st = ST_ADDR;
                OP_PP:                   st = wel ? ST_ADDR : ST_IGNORE;
                default:                 st = ST_IGNORE;
            endcase
        end
        return st;
    endfunction

    assign cs_s         = cs_sync_r[1];
    assign cs_fall_s    = cs_sync_r[2] & ~cs_sync_r[1];
    assign sclk_rise_s  = ~sclk_sync_r[2] & sclk_sync_r[1];
    assign sclk_fall_s  = sclk_sync_r[2] & ~sclk_sync_r[1];
    assign mosi_s       = mosi_sync_r[1];
    assign shift_full_s = {shift_r[6:0], mosi_s};
    assign addr_full_s  = {addr_r[22:0], mosi_s};
    assign status_s     = {6'b000000, wel_r, busy_r};
    assign prog_we_s    = (state_r == ST_DATA_IN) && !cs_s && sclk_rise_s && (bit_cnt_r[2:0] == 3'd7);

    // Byte loaded into the output shifter at each byte boundary (status is live, READ follows addr_r)
    always_comb begin
        out_src_s = 8'hFF;
        case (opcode_r)
            OP_RDSR:  out_src_s = status_s;
            OP_JEDEC: out_src_s = id_byte(id_idx_r);
            OP_READ:  out_src_s = mem_r[addr_r[AW-1:0]];
            default:  out_src_s = 8'hFF;
        endcase
    end

    // Next-state logic; a high CS always returns to IDLE and wins over a coincident SCLK edge
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) next_state_s = ST_CMD;
                else           next_state_s = ST_IDLE;
            end
            ST_CMD: begin
                if (cs_s)                                       next_state_s = ST_IDLE;
                else if (sclk_rise_s && (bit_cnt_r == 5'd7))    next_state_s = decode_op(shift_full_s, busy_r, wel_r);
                else                                            next_state_s = ST_CMD;
            end
            ST_ADDR: begin
                if (cs_s)                                       next_state_s = ST_IDLE;
                else if (sclk_rise_s && (bit_cnt_r == 5'd23))   next_state_s = (opcode_r == OP_READ) ? ST_DATA_OUT : ST_DATA_IN;
                else                                            next_state_s = ST_ADDR;
            end
            ST_DATA_OUT, ST_DATA_IN, ST_WAIT_CS, ST_IGNORE: begin
                if (cs_s) next_state_s = ST_IDLE;
                else      next_state_s = state_r;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Synchronizers, shifters, status bits, busy timer and CS-rise command execution
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_r      <= 3'b111;
            sclk_sync_r    <= 3'b000;
            mosi_sync_r    <= 2'b00;
            bit_cnt_r      <= 5'd0;
            shift_r        <= 8'h00;
            opcode_r       <= 8'h00;
            tx_r           <= 8'hFF;
            tx_cnt_r       <= 3'd0;
            id_idx_r       <= 2'd0;
            addr_r         <= 24'h000000;
            prog_any_r     <= 1'b0;
            miso_r         <= 1'b1;
            busy_r         <= 1'b0;
            wel_r          <= 1'b0;
            busy_cnt_r     <= '0;
            erase_active_r <= 1'b0;
            erase_addr_r   <= '0;
        end else begin
            cs_sync_r   <= {cs_sync_r[1:0], i_spi_cs};
            sclk_sync_r <= {sclk_sync_r[1:0], i_spi_clk};
            mosi_sync_r <= {mosi_sync_r[0], i_spi_mosi};

            if (busy_r) begin
                if (busy_cnt_r == BUSY_ONE) begin
                    busy_r     <= 1'b0;
                    busy_cnt_r <= '0;
                end else begin
                    busy_cnt_r <= busy_cnt_r - BUSY_ONE;
                end
            end

            if (erase_active_r) begin
                erase_addr_r <= erase_addr_r + AW'(1);
                if (erase_addr_r == LAST_ADDR) erase_active_r <= 1'b0;
            end

            if ((state_r != ST_IDLE) && cs_s) begin
                miso_r    <= 1'b1;
                bit_cnt_r <= 5'd0;
                if (state_r == ST_WAIT_CS) begin
                    case (opcode_r)
                        OP_WREN: wel_r <= 1'b1;
                        OP_WRDI: wel_r <= 1'b0;
                        OP_CE: begin
                            if (wel_r && !busy_r) begin
                                busy_r         <= 1'b1;
                                busy_cnt_r     <= BUSY_ERASE;
                                wel_r          <= 1'b0;
                                erase_active_r <= 1'b1;
                                erase_addr_r   <= '0;
                            end
                        end
                        default: ;
                    endcase
                end else if ((state_r == ST_DATA_IN) && prog_any_r) begin
                    busy_r     <= 1'b1;
                    busy_cnt_r <= BUSY_PROG;
                    wel_r      <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_fall_s) begin
                            bit_cnt_r <= 5'd0;
                            miso_r    <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise_s) begin
                            shift_r <= shift_full_s;
                            if (bit_cnt_r == 5'd7) begin
                                opcode_r   <= shift_full_s;
                                bit_cnt_r  <= 5'd0;
                                prog_any_r <= 1'b0;
                                tx_cnt_r   <= 3'd0;
                                id_idx_r   <= 2'd1;
                                tx_r       <= (shift_full_s == OP_RDSR) ? status_s : id_byte(2'd0);
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise_s) begin
                            if (bit_cnt_r == 5'd23) begin
                                bit_cnt_r <= 5'd0;
                                tx_cnt_r  <= 3'd0;
                                if (opcode_r == OP_READ) begin
                                    tx_r   <= mem_r[addr_full_s[AW-1:0]];
                                    addr_r <= addr_full_s + 24'd1;
                                end else begin
                                    addr_r <= addr_full_s;
                                end
                            end else begin
                                addr_r    <= addr_full_s;
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_DATA_OUT: begin
                        if (sclk_fall_s) begin
                            miso_r   <= tx_r[7];
                            tx_cnt_r <= tx_cnt_r + 3'd1;
                            if (tx_cnt_r == 3'd7) begin
                                tx_r   <= out_src_s;
                                addr_r <= addr_r + 24'd1;
                                if (id_idx_r != 2'd3) id_idx_r <= id_idx_r + 2'd1;
                            end else begin
                                tx_r <= {tx_r[6:0], 1'b0};
                            end
                        end
                    end
                    ST_DATA_IN: begin
                        if (sclk_rise_s) begin
                            shift_r <= shift_full_s;
                            if (bit_cnt_r[2:0] == 3'd7) begin
                                // page program wraps inside the 256-byte page
                                addr_r     <= {addr_r[23:8], addr_r[7:0] + 8'd1};
                                prog_any_r <= 1'b1;
                                bit_cnt_r  <= 5'd0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage write port: erase walk or NOR-style AND programming; contents survive reset
    always_ff @(posedge clk) begin
        if (erase_active_r)  mem_r[erase_addr_r] <= 8'hFF;
        else if (prog_we_s)  mem_r[addr_r[AW-1:0]] <= mem_r[addr_r[AW-1:0]] & shift_full_s;
    end

    assign o_spi_miso = miso_r;
    assign o_busy     = busy_r;
    assign o_wel      = wel_r;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Self-checking bench for spi_flash_slave: table of SPI transactions with a byte scoreboard,
// plus hand sequences for erase polling, busy timing, aborted opcode and mid-program reset.
module tb_spi_flash_slave;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cs = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso, busy, wel;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [8*10-1:0] name;
        logic [63:0]     tx;
        int              nbytes;
        int              rx_from;
        int              n_exp;
        logic [31:0]     exp;
        int              post;
    } vec_t;

    vec_t vecs[21];

    spi_flash_slave #(
        .P_MEM_DEPTH  (256),
        .P_PROG_CYCLES(64),
        .P_JEDEC_ID   (24'hEF4018)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_spi_cs  (cs),
        .i_spi_clk (sclk),
        .i_spi_mosi(mosi),
        .o_spi_miso(miso),
        .o_busy    (busy),
        .o_wel     (wel)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input logic [8*10-1:0] nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %0s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic spi_xfer(input logic [63:0] tx, input int nbits, input bit keep_cs, output logic [63:0] rx);
        rx = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[63-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx[63-i] = miso;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        if (!keep_cs) begin
            repeat (HALF) @(negedge clk);
            cs = 1'b1;
            mosi = 1'b0;
        end
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busy_end", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] rx;
        logic [7:0]  e;
        for (int j = 0; j < v.n_exp; j++) exp_q.push_back(v.exp[31-8*j -: 8]);
        spi_xfer(v.tx, v.nbytes * 8, 1'b0, rx);
        for (int j = 0; j < v.n_exp; j++) begin
            if (exp_q.size() == 0) begin
                e = 8'hXX;
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
            end
            check(v.name, {24'b0, rx[63-8*(v.rx_from+j) -: 8]}, {24'b0, e});
        end
        repeat (6) @(negedge clk);
        check("miso_idle", {31'b0, miso}, 32'd1);
        if (v.post == 1) wait_busy();
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) run_vec(vecs[k]);
    endtask

    initial begin
        logic [63:0] rx;
        int n;
        int cnt;
        vec_t v_rd40;

        vecs[0]  = '{"jedec",     64'h9F00_0000_0000_0000, 5, 1, 4, 32'hEF40_1800, 0};
        vecs[1]  = '{"wren",      64'h0600_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[2]  = '{"erase",     64'hC700_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[3]  = '{"rdsr_ers",  64'h0500_0000_0000_0000, 2, 1, 1, 32'h0100_0000, 0};
        vecs[4]  = '{"pp_nowel",  64'h0200_0010_A500_0000, 5, 0, 0, 32'h0000_0000, 0};
        vecs[5]  = '{"rdsr_0",    64'h0500_0000_0000_0000, 2, 1, 1, 32'h0000_0000, 0};
        vecs[6]  = '{"rd_10",     64'h0300_0010_0000_0000, 5, 4, 1, 32'hFF00_0000, 0};
        vecs[7]  = '{"wren",      64'h0600_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[8]  = '{"rdsr_wel",  64'h0500_0000_0000_0000, 2, 1, 1, 32'h0200_0000, 0};
        vecs[9]  = '{"wrdi",      64'h0400_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[10] = '{"rdsr_clr",  64'h0500_0000_0000_0000, 2, 1, 1, 32'h0000_0000, 0};
        vecs[11] = '{"wren",      64'h0600_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[12] = '{"rdsr_done", 64'h0500_0000_0000_0000, 2, 1, 1, 32'h0000_0000, 0};
        vecs[13] = '{"rd_fe",     64'h0300_00FE_0000_0000, 6, 4, 2, 32'h1122_0000, 0};
        vecs[14] = '{"rd_00",     64'h0300_0000_0000_0000, 5, 4, 1, 32'h3300_0000, 0};
        vecs[15] = '{"wren",      64'h0600_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[16] = '{"pp_f0",     64'h0200_0020_F000_0000, 5, 0, 0, 32'h0000_0000, 1};
        vecs[17] = '{"wren",      64'h0600_0000_0000_0000, 1, 0, 0, 32'h0000_0000, 0};
        vecs[18] = '{"pp_3c",     64'h0200_0020_3C00_0000, 5, 0, 0, 32'h0000_0000, 1};
        vecs[19] = '{"rd_20",     64'h0300_0020_0000_0000, 5, 4, 1, 32'h3000_0000, 0};
        vecs[20] = '{"rd_ff",     64'h0300_00FF_0000_0000, 6, 4, 2, 32'h2233_0000, 0};
        v_rd40   = '{"rd_40",     64'h0300_0040_0000_0000, 5, 4, 1, 32'h5A00_0000, 0};

        repeat (5) @(negedge clk);
        check("rst_miso", {31'b0, miso}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wel",  {31'b0, wel},  32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_range(0, 3);

        // poll status until the chip erase completes
        n = 0;
        rx = '0;
        rx[55:48] = 8'hFF;
        while (rx[55:48] != 8'h00 && n < 20) begin
            spi_xfer(64'h0500_0000_0000_0000, 16, 1'b0, rx);
            repeat (6) @(negedge clk);
            n++;
        end
        check("ers_poll", {24'b0, rx[55:48]}, 32'd0);

        run_range(4, 11);
        check("wel_pin", {31'b0, wel}, 32'd1);

        // page program across the page end, then time the busy window
        spi_xfer(64'h0200_00FE_1122_3300, 56, 1'b0, rx);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cyc", cnt, 32'd64);
        check("wel_pp", {31'b0, wel}, 32'd0);

        run_range(12, 20);
        run_vec('{"rd_hi", 64'h0301_23FF_0000_0000, 5, 4, 1, 32'h2200_0000, 0});

        // opcode aborted after 5 bits, then a clean JEDEC read
        spi_xfer(64'h9F00_0000_0000_0000, 5, 1'b0, rx);
        repeat (6) @(negedge clk);
        run_vec(vecs[0]);

        // reset in the middle of a page program after one full byte
        run_vec(vecs[1]);
        spi_xfer(64'h0200_0040_5A00_0000, 43, 1'b1, rx);
        check("wel_pre", {31'b0, wel}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstm_busy", {31'b0, busy}, 32'd0);
        check("rstm_wel",  {31'b0, wel},  32'd0);
        check("rstm_miso", {31'b0, miso}, 32'd1);
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(v_rd40);

        check("sb_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
